vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_pkg.sv | 16 +
 rtl/vram_fill_seq.sv | 72 +++++++
 rtl/vram_arbiter.sv | 134 +++++++++++++
 tb/tb_vram_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM definitions: fill FSM states, round-robin select and byte-enable constants.
package vram_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } fill_state_e;

    typedef enum logic {
        RR_CPU,
        RR_DMA
    } rr_sel_e;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/vram_fill_seq.sv
// Fill sequencer: latches a base/count/value job and walks the address range one
// write per granted slot, wrapping modulo 2^AW.
module vram_fill_seq
    import vram_pkg::*;
#(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   count,
    input  logic [DW-1:0] value,
    input  logic          issue,
    output logic          busy,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          done
);

    fill_state_e   state_q;
    fill_state_e   state_d;
    logic [AW:0]   remain_q;
    logic          load;
    logic          last;
    logic          last_q;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        last    = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start && (count != '0)) begin
                state_d = ST_FILL;
                load    = 1'b1;
            end
        end else begin
            if (issue && (remain_q == (AW+1)'(1))) begin
                state_d = ST_IDLE;
                last    = 1'b1;
            end
        end
    end

    // Done trails the final write by one edge so it never overlaps the last mem_wren cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr     <= '0;
            remain_q <= '0;
            data     <= '0;
            last_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last;
            done    <= last_q;
            if (load) begin
                addr     <= base;
                remain_q <= count;
                data     <= value;
            end else if (issue && (state_q == ST_FILL)) begin
                addr     <= addr + AW'(1);
                remain_q <= remain_q - (AW+1)'(1);
            end
        end
    end

    assign busy = (state_q == ST_FILL);

endmodule

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: CPU/DMA round-robin with a lowest-priority fill engine,
// a registered memory command stage and a two-edge read-return pipeline.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW = 14,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [3:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic          dma_rvalid,
    output logic [DW-1:0] rdata,
    input  logic          fill_start,
    input  logic [AW-1:0] fill_base,
    input  logic [AW:0]   fill_count,
    input  logic [DW-1:0] fill_value,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wren,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_q
);

    rr_sel_e       rr_last_q;
    logic          cpu_elig;
    logic          dma_elig;
    logic          gnt_cpu;
    logic          gnt_dma;
    logic          gnt_fill;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic [1:0]    vld_p0;
    logic [1:0]    vld_p1;

    // A requester whose ack is showing this cycle is not eligible again until the next edge.
    assign cpu_elig = cpu_req & ~cpu_ack;
    assign dma_elig = dma_req & ~dma_ack;

    always_comb begin
        gnt_cpu = cpu_elig;
        gnt_dma = dma_elig;
        if (cpu_elig && dma_elig) begin
            gnt_cpu = (rr_last_q == RR_DMA);
            gnt_dma = (rr_last_q == RR_CPU);
        end
    end

    assign gnt_fill = fill_busy & ~cpu_elig & ~dma_elig;

    vram_fill_seq #(
        .AW(AW),
        .DW(DW)
    ) u_fill_seq (
        .clock (clock),
        .reset (reset),
        .start (fill_start),
        .base  (fill_base),
        .count (fill_count),
        .value (fill_value),
        .issue (gnt_fill),
        .busy  (fill_busy),
        .addr  (fill_addr),
        .data  (fill_data),
        .done  (fill_done)
    );

    // Stage p0: command issue; DMA as last winner means CPU is favoured out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            rr_last_q <= RR_DMA;
            mem_addr  <= '0;
            mem_wren  <= '0;
            mem_wdata <= '0;
            vld_p0    <= '0;
        end else begin
            cpu_ack  <= gnt_cpu;
            dma_ack  <= gnt_dma;
            mem_wren <= '0;
            vld_p0   <= {gnt_dma & ~dma_we, gnt_cpu & ~cpu_we};
            if (gnt_cpu) begin
                rr_last_q <= RR_CPU;
                mem_addr  <= cpu_addr;
                if (cpu_we) begin
                    mem_wren  <= cpu_be;
                    mem_wdata <= cpu_wdata;
                end
            end else if (gnt_dma) begin
                rr_last_q <= RR_DMA;
                mem_addr  <= dma_addr;
                if (dma_we) begin
                    mem_wren  <= BE_FULL;
                    mem_wdata <= dma_wdata;
                end
            end else if (gnt_fill) begin
                mem_addr  <= fill_addr;
                mem_wren  <= BE_FULL;
                mem_wdata <= fill_data;
            end
        end
    end

    // Stage p1/p2: wait out the memory's registered read, then capture mem_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1     <= '0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            rdata      <= '0;
        end else begin
            vld_p1     <= vld_p0;
            cpu_rvalid <= vld_p1[0];
            dma_rvalid <= vld_p1[1];
            if (|vld_p1) begin
                rdata <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized CPU/DMA
// traffic checked against a transaction-level reference model.
module tb_vram_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int NRAND = 240;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, cpu_ack, cpu_rvalid;
    logic [3:0]    cpu_be;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          dma_req, dma_we, dma_ack, dma_rvalid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] rdata;
    logic          fill_start, fill_busy, fill_done;
    logic [AW-1:0] fill_base;
    logic [AW:0]   fill_count;
    logic [DW-1:0] fill_value;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wren;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    int n_checks = 0;
    int n_pass   = 0;

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .rdata(rdata),
        .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    // Memory with one-cycle registered read and per-byte write enables.
    always @(posedge clock) begin
        mem_q <= mem[mem_addr];
        for (int b = 0; b < 4; b++)
            if (mem_wren[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        fill_start = 0; fill_base = '0; fill_count = '0; fill_value = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic cpu_read_word(input logic [AW-1:0] a, output logic [DW-1:0] d);
        d = 'x;
        cpu_req = 1; cpu_we = 0; cpu_addr = a;
        tick();
        cpu_req = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cpu_rvalid === 1'b1) begin
                d = rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        n_checks++; if ({cpu_ack, cpu_rvalid, dma_ack, dma_rvalid} !== 4'b0) $display("FAIL reset_handshake: got %b want 0000", {cpu_ack, cpu_rvalid, dma_ack, dma_rvalid}); else n_pass++;
        n_checks++; if ({fill_busy, fill_done} !== 2'b0) $display("FAIL reset_fill: got %b want 00", {fill_busy, fill_done}); else n_pass++;
        n_checks++; if (mem_wren !== 4'h0) $display("FAIL reset_wren: got %h want 0", mem_wren); else n_pass++;
        n_checks++; if (mem_addr !== '0) $display("FAIL reset_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if (mem_wdata !== '0) $display("FAIL reset_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_checks++; if (rdata !== '0) $display("FAIL reset_rdata: got %h want 0", rdata); else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if ({cpu_ack, dma_ack, mem_wren} !== 6'b0) $display("FAIL reset_idle: got %b want 0", {cpu_ack, dma_ack, mem_wren}); else n_pass++;
    endtask

    task automatic test_cpu_read();
        do_reset();
        preload(14'h0010, 32'hDEADBEEF);
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0010;
        tick();
        cpu_req = 0;
        n_checks++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) $display("FAIL rd_ack: got cpu=%b dma=%b want 1 0", cpu_ack, dma_ack); else n_pass++;
        n_checks++; if (mem_addr !== 14'h0010 || mem_wren !== 4'h0) $display("FAIL rd_cmd: got addr=%h wren=%h want 0010 0", mem_addr, mem_wren); else n_pass++;
        tick();
        n_checks++; if (cpu_ack !== 1'b0 || cpu_rvalid !== 1'b0) $display("FAIL rd_gap: got ack=%b rvalid=%b want 0 0", cpu_ack, cpu_rvalid); else n_pass++;
        tick();
        n_checks++; if (cpu_rvalid !== 1'b1 || rdata !== 32'hDEADBEEF) $display("FAIL rd_data: got rvalid=%b rdata=%h want 1 deadbeef", cpu_rvalid, rdata); else n_pass++;
        tick();
        n_checks++; if (cpu_rvalid !== 1'b0 || rdata !== 32'hDEADBEEF) $display("FAIL rd_hold: got rvalid=%b rdata=%h want 0 deadbeef", cpu_rvalid, rdata); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic exp_cpu;
        idle_inputs();
        reset = 1'b1;
        cpu_req = 1; cpu_addr = 14'h0100;
        dma_req = 1; dma_addr = 14'h0200;
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp_cpu = (k % 2 == 0);
            tick();
            n_checks++; if (cpu_ack !== exp_cpu || dma_ack !== !exp_cpu) $display("FAIL rr_grant%0d: got cpu=%b dma=%b want %b %b", k, cpu_ack, dma_ack, exp_cpu, !exp_cpu); else n_pass++;
            n_checks++; if (mem_addr !== (exp_cpu ? 14'h0100 : 14'h0200)) $display("FAIL rr_addr%0d: got %h want %h", k, mem_addr, exp_cpu ? 14'h0100 : 14'h0200); else n_pass++;
        end
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic test_write_be();
        logic [DW-1:0] d;
        do_reset();
        preload(14'h0020, 32'hAABBCCDD);
        cpu_req = 1; cpu_we = 1; cpu_be = 4'b0101; cpu_addr = 14'h0020; cpu_wdata = 32'h11223344;
        tick();
        cpu_req = 0; cpu_we = 0;
        n_checks++; if (cpu_ack !== 1'b1 || mem_wren !== 4'b0101) $display("FAIL be_cmd: got ack=%b wren=%b want 1 0101", cpu_ack, mem_wren); else n_pass++;
        n_checks++; if (mem_addr !== 14'h0020 || mem_wdata !== 32'h11223344) $display("FAIL be_data: got %h/%h want 0020/11223344", mem_addr, mem_wdata); else n_pass++;
        tick();
        n_checks++; if (mem_wren !== 4'h0) $display("FAIL be_once: got %b want 0000", mem_wren); else n_pass++;
        cpu_read_word(14'h0020, d);
        n_checks++; if (d !== 32'hAA22CC44) $display("FAIL be_readback: got %h want aa22cc44", d); else n_pass++;
        cpu_req = 1; cpu_we = 1; cpu_be = 4'b0000; cpu_addr = 14'h0020; cpu_wdata = 32'hFFFFFFFF;
        tick();
        cpu_req = 0; cpu_we = 0;
        n_checks++; if (cpu_ack !== 1'b1 || mem_wren !== 4'h0) $display("FAIL be_zero: got ack=%b wren=%b want 1 0000", cpu_ack, mem_wren); else n_pass++;
        tick();
        cpu_read_word(14'h0020, d);
        n_checks++; if (d !== 32'hAA22CC44) $display("FAIL be_zero_rb: got %h want aa22cc44", d); else n_pass++;
    endtask

    task automatic test_fill_wrap();
        int writes, dones, last_k, done_k, stray;
        logic [AW-1:0] exp_a;
        do_reset();
        fill_start = 1; fill_base = 14'h3FFE; fill_count = 4; fill_value = 32'hA5A5A5A5;
        tick();
        fill_start = 0;
        n_checks++; if (fill_busy !== 1'b1) $display("FAIL fill_busy_on: got %b want 1", fill_busy); else n_pass++;
        writes = 0; dones = 0; last_k = -1; done_k = -1; stray = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 1) begin
                fill_start = 1; fill_base = 14'h0100; fill_count = 3; fill_value = '0;
            end else begin
                fill_start = 0;
            end
            tick();
            if (mem_wren === 4'hF) begin
                exp_a = AW'((32'h3FFE + writes) % (1 << AW));
                n_checks++; if (mem_addr !== exp_a || mem_wdata !== 32'hA5A5A5A5) $display("FAIL fill_wr%0d: got %h/%h want %h/a5a5a5a5", writes, mem_addr, mem_wdata, exp_a); else n_pass++;
                writes++;
                last_k = k;
            end else if (mem_wren !== 4'h0) begin
                stray++;
            end
            if (fill_done === 1'b1) begin
                dones++;
                done_k = k;
            end
        end
        n_checks++; if (writes != 4 || stray != 0) $display("FAIL fill_count: got %0d writes %0d stray want 4 0", writes, stray); else n_pass++;
        n_checks++; if (dones != 1 || done_k != last_k + 1) $display("FAIL fill_done: got %0d pulses at %0d want 1 at %0d", dones, done_k, last_k + 1); else n_pass++;
        n_checks++; if (fill_busy !== 1'b0) $display("FAIL fill_busy_off: got %b want 0", fill_busy); else n_pass++;
        n_checks++; if (mem[0] !== 32'hA5A5A5A5) $display("FAIL fill_wrap_mem: got %h want a5a5a5a5", mem[0]); else n_pass++;
        fill_start = 1; fill_base = 14'h0200; fill_count = 0;
        tick();
        fill_start = 0;
        n_checks++; if (fill_busy !== 1'b0) $display("FAIL fill_zero_busy: got %b want 0", fill_busy); else n_pass++;
        dones = 0;
        repeat (4) begin
            tick();
            if (fill_done !== 1'b0 || mem_wren !== 4'h0) dones++;
        end
        n_checks++; if (dones != 0) $display("FAIL fill_zero_done: got %0d active cycles want 0", dones); else n_pass++;
    endtask

    task automatic test_fill_full();
        byte unsigned seen [0:(1<<AW)-1];
        int writes, dones, bad;
        do_reset();
        for (int a = 0; a < (1 << AW); a++) seen[a] = 0;
        fill_start = 1; fill_base = 14'h1234; fill_count = (AW+1)'(1 << AW); fill_value = 32'h0F0F0F0F;
        tick();
        fill_start = 0;
        writes = 0; dones = 0; bad = 0;
        for (int k = 0; k < (1 << AW) + 8; k++) begin
            tick();
            if (mem_wren === 4'hF) begin
                seen[mem_addr]++;
                writes++;
            end
            if (fill_done === 1'b1) dones++;
        end
        for (int a = 0; a < (1 << AW); a++) if (seen[a] != 1) bad++;
        n_checks++; if (writes != (1 << AW) || bad != 0) $display("FAIL full_cover: got %0d writes %0d bad words want %0d 0", writes, bad, 1 << AW); else n_pass++;
        n_checks++; if (dones != 1 || fill_busy !== 1'b0) $display("FAIL full_done: got %0d pulses busy=%b want 1 0", dones, fill_busy); else n_pass++;
    endtask

    task automatic test_fill_contend();
        logic exp_ack;
        int writes, dones, last_k, done_k, early;
        do_reset();
        fill_start = 1; fill_base = 14'h0300; fill_count = 4; fill_value = 32'h5A5A5A5A;
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0010;
        exp_ack = 0; writes = 0; dones = 0; last_k = -1; done_k = -1; early = 0;
        for (int k = 0; k < 16; k++) begin
            exp_ack = cpu_req && !exp_ack;
            tick();
            fill_start = 0;
            n_checks++; if (cpu_ack !== exp_ack) $display("FAIL contend_ack%0d: got %b want %b", k, cpu_ack, exp_ack); else n_pass++;
            if (mem_wren === 4'hF) begin
                n_checks++; if (mem_addr !== 14'h0300 + 14'(writes)) $display("FAIL contend_addr%0d: got %h want %h", writes, mem_addr, 14'h0300 + 14'(writes)); else n_pass++;
                writes++;
                last_k = k;
            end
            if (fill_done === 1'b1) begin
                dones++;
                done_k = k;
                if (writes != 4) early++;
            end
        end
        cpu_req = 0;
        n_checks++; if (writes != 4 || last_k != 7) $display("FAIL contend_stall: got %0d writes last at %0d want 4 at 7", writes, last_k); else n_pass++;
        n_checks++; if (dones != 1 || done_k != 8 || early != 0) $display("FAIL contend_done: got %0d pulses at %0d early=%0d want 1 at 8", dones, done_k, early); else n_pass++;
        repeat (4) tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] shadow [0:15];
        int            rv_who [0:NRAND+3];
        logic [DW-1:0] rv_dat [0:NRAND+3];
        logic          m_cack, m_dack, c_el, d_el, we;
        int            m_last, win;
        logic [AW-1:0] e_addr, a;
        logic [3:0]    e_wren;
        logic [DW-1:0] e_wdata, e_rdata, wd;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            shadow[i] = $urandom;
            preload(AW'(i), shadow[i]);
        end
        for (int i = 0; i <= NRAND + 3; i++) rv_who[i] = 0;
        m_cack = 0; m_dack = 0; m_last = 2;
        e_addr = '0; e_wren = '0; e_wdata = '0; e_rdata = '0;
        for (int i = 0; i < NRAND + 3; i++) begin
            if (i > 0) begin
                n_checks++; if (cpu_ack !== m_cack || dma_ack !== m_dack) $display("FAIL rand_ack%0d: got %b%b want %b%b", i, cpu_ack, dma_ack, m_cack, m_dack); else n_pass++;
                n_checks++; if (mem_wren !== e_wren || mem_addr !== e_addr) $display("FAIL rand_cmd%0d: got %h@%h want %h@%h", i, mem_wren, mem_addr, e_wren, e_addr); else n_pass++;
                if (e_wren != 0) begin
                    n_checks++; if (mem_wdata !== e_wdata) $display("FAIL rand_wdata%0d: got %h want %h", i, mem_wdata, e_wdata); else n_pass++;
                end
            end
            if (rv_who[i] != 0) e_rdata = rv_dat[i];
            n_checks++; if (cpu_rvalid !== (rv_who[i] == 1) || dma_rvalid !== (rv_who[i] == 2)) $display("FAIL rand_rvalid%0d: got %b%b want who=%0d", i, cpu_rvalid, dma_rvalid, rv_who[i]); else n_pass++;
            n_checks++; if (rdata !== e_rdata) $display("FAIL rand_rdata%0d: got %h want %h", i, rdata, e_rdata); else n_pass++;
            if (i < NRAND) begin
                cpu_req = ($urandom_range(0, 9) < 6); cpu_we = 1'($urandom); cpu_be = 4'($urandom);
                cpu_addr = AW'($urandom_range(0, 15)); cpu_wdata = $urandom;
                dma_req = ($urandom_range(0, 9) < 6); dma_we = 1'($urandom);
                dma_addr = AW'($urandom_range(0, 15)); dma_wdata = $urandom;
            end else begin
                idle_inputs();
            end
            c_el = cpu_req && !m_cack;
            d_el = dma_req && !m_dack;
            win = 0;
            if (c_el && d_el) win = (m_last == 1) ? 2 : 1;
            else if (c_el) win = 1;
            else if (d_el) win = 2;
            m_cack = (win == 1);
            m_dack = (win == 2);
            e_wren = '0;
            if (win != 0) begin
                m_last = win;
                we = (win == 1) ? cpu_we : dma_we;
                a  = (win == 1) ? cpu_addr : dma_addr;
                wd = (win == 1) ? cpu_wdata : dma_wdata;
                e_addr = a;
                if (we) begin
                    e_wren  = (win == 1) ? cpu_be : 4'hF;
                    e_wdata = wd;
                    for (int b = 0; b < 4; b++)
                        if (e_wren[b]) shadow[a[3:0]][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    rv_who[i+3] = win;
                    rv_dat[i+3] = shadow[a[3:0]];
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        preload(14'h0040, 32'h12345678);
        fill_start = 1; fill_base = 14'h0500; fill_count = 8; fill_value = 32'h77777777;
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0040;
        tick();
        fill_start = 0; cpu_req = 0;
        tick();
        n_checks++; if (mem_wren !== 4'hF || fill_busy !== 1'b1) $display("FAIL mid_active: got wren=%h busy=%b want f 1", mem_wren, fill_busy); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if ({cpu_ack, cpu_rvalid, dma_ack, dma_rvalid, fill_busy, fill_done, mem_wren} !== 10'b0) $display("FAIL mid_ctrl: got %b want 0", {cpu_ack, cpu_rvalid, dma_ack, dma_rvalid, fill_busy, fill_done, mem_wren}); else n_pass++;
        n_checks++; if (mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) $display("FAIL mid_data: got %h %h %h want 0 0 0", mem_addr, mem_wdata, rdata); else n_pass++;
        tick();
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if ({cpu_ack, cpu_rvalid, dma_ack, dma_rvalid, fill_busy, fill_done, mem_wren} !== 10'b0) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL mid_after: got %0d active cycles want 0", bad); else n_pass++;
        n_checks++; if (rdata !== '0) $display("FAIL mid_rdata: got %h want 0", rdata); else n_pass++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_cpu_read();
        test_round_robin();
        test_write_be();
        test_fill_wrap();
        test_fill_contend();
        test_fill_full();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
